mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 128 ++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Two-port (fetch/data) arbiter onto a single synchronous-read memory port.
// Grants are combinational; read-valid strobes are registered one cycle later.
module mem_port_arbiter #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8,
    parameter int PRIO_DATA  = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              if_req,
    input  logic              if_we,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic [DATA_W-1:0] if_wdata,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,

    output logic              if_gnt,
    output logic              d_gnt,
    output logic              if_rvalid,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              if_stall,

    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic       OWNER_IF   = 1'b0;
    localparam logic       OWNER_D    = 1'b1;
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [3:0] starve_cnt;
    logic       last_owner;
    logic       arb_on;
    logic       starved;
    logic       d_wins;

    assign arb_on  = !reset;
    assign starved = (starve_cnt == STARVE_LIM);

    // Contention winner: starvation override first, then priority or round-robin.
    always_comb begin
        d_wins = 1'b0;
        if (starved) begin
            d_wins = 1'b0;
        end else if (PRIO_DATA != 0) begin
            d_wins = 1'b1;
        end else begin
            d_wins = (last_owner == OWNER_IF);
        end
    end

    always_comb begin
        if_gnt = 1'b0;
        d_gnt  = 1'b0;
        unique case (1'b1)
            (arb_on && if_req && !d_req): if_gnt = 1'b1;
            (arb_on && d_req && !if_req): d_gnt  = 1'b1;
            (arb_on && d_req && if_req): begin
                d_gnt  = d_wins;
                if_gnt = !d_wins;
            end
            default: ;
        endcase
    end

    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        unique case (1'b1)
            if_gnt: begin
                mem_addr  = if_addr;
                mem_we    = if_we;
                mem_wdata = if_wdata;
            end
            d_gnt: begin
                mem_addr  = d_addr;
                mem_we    = d_we;
                mem_wdata = d_wdata;
            end
            default: ;
        endcase
    end

    assign if_stall = arb_on && if_req && !if_gnt;
    assign if_rdata = mem_rdata;
    assign d_rdata  = mem_rdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;
        end else begin
            if_rvalid <= if_gnt && !if_we;
            d_rvalid  <= d_gnt && !d_we;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_owner <= OWNER_IF;
        end else if (if_gnt) begin
            last_owner <= OWNER_IF;
        end else if (d_gnt) begin
            last_owner <= OWNER_D;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt <= 4'd0;
        end else if (!if_req || if_gnt) begin
            starve_cnt <= 4'd0;
        end else if (starve_cnt < STARVE_LIM) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

endmodule
